uart_boot_loader: RTL

- Upstream of the CPU/memory top level.
- Receives a program image over a UART serial line (8N1) and writes it word by word into instruction memory through a write port.
- Holds the CPU in reset until the whole image is loaded, then releases it.
- Allows new programs to run on the processor without resynthesis.

---
 rtl/uart_boot_loader.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: receives a length-prefixed image, writes it word by word
// into instruction memory and releases the CPU once the whole image has landed.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 6,
    parameter int MAX_WORDS    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]      MAX_LEN   = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_DONE, LD_ERROR} ld_state_t;

    logic             rx_meta_r;
    logic             rx_s;
    rx_state_t        rx_state_r, rx_state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic             byte_valid_s;
    logic             rx_err_s;

    ld_state_t        ld_state_r, ld_state_nxt_s;
    logic [15:0]      len_r;
    logic [15:0]      len_full_s;
    logic [1:0]       byte_idx_r;
    logic [15:0]      word_cnt_r;
    logic [23:0]      asm_r;
    logic             word_wr_s;
    logic             done_set_s;
    logic             err_set_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Receiver state and bit-timing registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
        end
    end

    // Receiver next-state: start bit checked at mid-bit, then one sample per bit period
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        cnt_nxt_s      = cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        shift_nxt_s    = shift_r;
        byte_valid_s   = 1'b0;
        rx_err_s       = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (!rx_s) begin
                    rx_state_nxt_s = RX_START;
                end else begin
                    rx_state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s     = CNT_ZERO;
                    bit_idx_nxt_s = 3'd0;
                    if (rx_s) begin
                        rx_state_nxt_s = RX_IDLE;
                    end else begin
                        rx_state_nxt_s = RX_DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    shift_nxt_s = {rx_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        rx_state_nxt_s = RX_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s      = CNT_ZERO;
                    rx_state_nxt_s = RX_IDLE;
                    if (rx_s) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        rx_err_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_nxt_s = RX_IDLE;
                cnt_nxt_s      = CNT_ZERO;
            end
        endcase
    end

    assign len_full_s = {shift_r, len_r[7:0]};

    // Loader state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_r <= LD_LEN_LO;
        end else begin
            ld_state_r <= ld_state_nxt_s;
        end
    end

    // Loader next-state and write/done/error strobes
    always_comb begin
        ld_state_nxt_s = ld_state_r;
        word_wr_s      = 1'b0;
        done_set_s     = 1'b0;
        err_set_s      = 1'b0;
        case (ld_state_r)
            LD_LEN_LO: begin
                if (rx_err_s) begin
                    ld_state_nxt_s = LD_ERROR;
                    err_set_s      = 1'b1;
                end else if (byte_valid_s) begin
                    ld_state_nxt_s = LD_LEN_HI;
                end else begin
                    ld_state_nxt_s = LD_LEN_LO;
                end
            end
            LD_LEN_HI: begin
                if (rx_err_s) begin
                    ld_state_nxt_s = LD_ERROR;
                    err_set_s      = 1'b1;
                end else if (byte_valid_s) begin
                    // An empty image finishes straight away; oversize images are rejected
                    if (len_full_s == 16'd0) begin
                        ld_state_nxt_s = LD_DONE;
                        done_set_s     = 1'b1;
                    end else if (len_full_s > MAX_LEN) begin
                        ld_state_nxt_s = LD_ERROR;
                        err_set_s      = 1'b1;
                    end else begin
                        ld_state_nxt_s = LD_WORD;
                    end
                end else begin
                    ld_state_nxt_s = LD_LEN_HI;
                end
            end
            LD_WORD: begin
                if (rx_err_s) begin
                    ld_state_nxt_s = LD_ERROR;
                    err_set_s      = 1'b1;
                end else if (byte_valid_s && (byte_idx_r == 2'd3)) begin
                    word_wr_s = 1'b1;
                    if ((word_cnt_r + 16'd1) == len_r) begin
                        ld_state_nxt_s = LD_DONE;
                    end else begin
                        ld_state_nxt_s = LD_WORD;
                    end
                end else begin
                    ld_state_nxt_s = LD_WORD;
                end
            end
            LD_DONE: begin
                ld_state_nxt_s = LD_DONE;
                done_set_s     = 1'b1;
            end
            LD_ERROR: begin
                ld_state_nxt_s = LD_ERROR;
                err_set_s      = 1'b1;
            end
            default: begin
                ld_state_nxt_s = LD_ERROR;
                err_set_s      = 1'b1;
            end
        endcase
    end

    // Loader datapath: length capture, little-endian word assembly, registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r      <= 16'h0000;
            byte_idx_r <= 2'd0;
            word_cnt_r <= 16'h0000;
            asm_r      <= 24'h000000;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(0);
            imem_wdata <= 32'h00000000;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            imem_we   <= word_wr_s;
            cpu_hold  <= cpu_hold & ~done_set_s;
            load_done <= load_done | done_set_s;
            frame_err <= frame_err | err_set_s;
            if (word_wr_s) begin
                imem_wdata <= {shift_r, asm_r};
            end
            // Address advances after each pulse except the last, so it never wraps
            if (imem_we && (ld_state_r != LD_DONE)) begin
                imem_addr <= imem_addr + ADDR_W'(1);
            end
            if (byte_valid_s && (ld_state_r == LD_LEN_LO)) begin
                len_r[7:0] <= shift_r;
            end
            if (byte_valid_s && (ld_state_r == LD_LEN_HI)) begin
                len_r[15:8] <= shift_r;
                byte_idx_r  <= 2'd0;
                word_cnt_r  <= 16'h0000;
            end
            if (byte_valid_s && (ld_state_r == LD_WORD)) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    asm_r[7:0]   <= shift_r;
                    2'd1:    asm_r[15:8]  <= shift_r;
                    2'd2:    asm_r[23:16] <= shift_r;
                    default: word_cnt_r   <= word_cnt_r + 16'd1;
                endcase
            end
        end
    end

endmodule
